dylock_key_loader: RTL and testbench

Serial key-loading front end for the DyLock locked netlists. Accepts a bit-serial key frame over a valid/ready interface, assembles it in a shadow register, and commits it atomically to the parallel `static_key` bus that drives the `nonlinear_gen_16bit` tamper-key generator. The generator never sees a partially shifted key. Malformed or stalled frames are discarded and flagged.

---
 rtl/dylock_key_loader.sv | 146 ++++++++++++++
 tb/tb_dylock_key_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dylock_key_loader.sv
// Bit-serial key loader: assembles an MSB-first frame in a shadow register and commits it atomically.
// Define DYLOCK_KEY_PARITY_EN to require a trailing even-parity bit after the KEY_W data bits.
module dylock_key_loader #(
  parameter int KEY_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_valid_i,
  input  logic             key_bit_i,
  input  logic             key_sof_i,
  output logic             key_ready_o,
  output logic [KEY_W-1:0] static_key_o,
  output logic             key_update_o,
  output logic             key_loaded_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int CW = $clog2(KEY_W + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(KEY_W);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

`ifdef DYLOCK_KEY_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_COMMIT = 2'd2, S_PARITY = 2'd3} state_t;
  localparam state_t S_DATA_DONE = S_PARITY;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_COMMIT = 2'd2} state_t;
  localparam state_t S_DATA_DONE = S_COMMIT;
`endif

  state_t           state_q, state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [KEY_W-1:0] static_key_q;
  logic             key_update_q, key_loaded_q;
  logic             frame_err_q, frame_err_d;
  logic             xfer;

  assign xfer = key_valid_i & key_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A key_sof transfer in any accepting state (re)starts the frame with that bit as the MSB.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    count_d     = count_q;
    idle_d      = '0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer && key_sof_i) begin
          shadow_d          = '0;
          shadow_d[KEY_W-1] = key_bit_i;
          count_d           = CW'(1);
          state_d           = (count_d == COUNT_FULL) ? S_DATA_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (xfer) begin
          if (key_sof_i) begin
            shadow_d          = '0;
            shadow_d[KEY_W-1] = key_bit_i;
            count_d           = CW'(1);
            state_d           = (count_d == COUNT_FULL) ? S_DATA_DONE : S_SHIFT;
          end else begin
            for (int i = 0; i < KEY_W; i++) begin
              if (i == KEY_W - 1 - int'(count_q)) shadow_d[i] = key_bit_i;
            end
            count_d = count_q + CW'(1);
            if (count_d == COUNT_FULL) state_d = S_DATA_DONE;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
`ifdef DYLOCK_KEY_PARITY_EN
      S_PARITY: begin
        if (xfer) begin
          if (key_sof_i) begin
            shadow_d          = '0;
            shadow_d[KEY_W-1] = key_bit_i;
            count_d           = CW'(1);
            state_d           = (count_d == COUNT_FULL) ? S_DATA_DONE : S_SHIFT;
          end else if ((^shadow_q) ^ key_bit_i) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end else begin
            state_d = S_COMMIT;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
`endif
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    key_ready_o = !rst_i && (state_q != S_COMMIT);
    busy_o      = (state_q != S_IDLE);
  end

  // The generator-facing key only moves on the COMMIT exit edge, never mid-frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q     <= '0;
      count_q      <= '0;
      idle_q       <= '0;
      static_key_q <= '0;
      key_update_q <= 1'b0;
      key_loaded_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      count_q      <= count_d;
      idle_q       <= idle_d;
      frame_err_q  <= frame_err_d;
      key_update_q <= (state_q == S_COMMIT);
      if (state_q == S_COMMIT) begin
        static_key_q <= shadow_q;
        key_loaded_q <= 1'b1;
      end
    end
  end

  assign static_key_o = static_key_q;
  assign key_update_o = key_update_q;
  assign key_loaded_o = key_loaded_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_dylock_key_loader.sv
// Scoreboard bench for dylock_key_loader: the driver queues expected commits/errors, a monitor checks them.
module tb_dylock_key_loader;
  localparam int KEY_W   = 16;
  localparam int TIMEOUT = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_valid, key_bit, key_sof;
  logic             key_ready, key_update, key_loaded, frame_err, busy;
  logic [KEY_W-1:0] static_key;

  dylock_key_loader #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .key_valid_i(key_valid), .key_bit_i(key_bit), .key_sof_i(key_sof),
    .key_ready_o(key_ready), .static_key_o(static_key), .key_update_o(key_update),
    .key_loaded_o(key_loaded), .frame_err_o(frame_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [KEY_W-1:0] key; int cyc; } commit_t;
  commit_t commitQ[$];
  int      errQ[$];
  commit_t monE;
  int      monErrCyc;
  int      checks = 0;
  int      errors = 0;
  logic    monOn  = 1'b0;

  // Monitor: every key_update or frame_err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (monOn && !rst) begin
      if (key_update) begin
        checks++;
        if (commitQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_update: static_key=%h at cycle %0d, required no update", static_key, cyc);
        end else begin
          monE = commitQ.pop_front();
          if (static_key !== monE.key || key_loaded !== 1'b1 || cyc != monE.cyc) begin
            errors++;
            $display("[TB] FAIL commit: got key=%h loaded=%b cycle=%0d, required key=%h loaded=1 cycle=%0d",
                     static_key, key_loaded, cyc, monE.key, monE.cyc);
          end
        end
      end
      if (frame_err) begin
        checks++;
        if (errQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_frame_err: at cycle %0d, required no error", cyc);
        end else begin
          monErrCyc = errQ.pop_front();
          if (cyc != monErrCyc) begin
            errors++;
            $display("[TB] FAIL frame_err_time: got cycle %0d, required cycle %0d", cyc, monErrCyc);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one bit until accepted; returns the accepting edge number and how many cycles it stalled.
  task automatic sendBit(input logic b, input logic sof, output int edgeNum, output int stalls);
    logic r;
    edgeNum   = -1;
    stalls    = 0;
    key_valid = 1'b1;
    key_bit   = b;
    key_sof   = sof;
    for (int t = 0; t < 20 && edgeNum < 0; t++) begin
      @(negedge clk);
      r = key_ready;
      @(posedge clk);
      #1;
      if (r) edgeNum = cyc;
      else   stalls++;
    end
    key_valid = 1'b0;
    key_sof   = 1'b0;
    if (edgeNum < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: bit not accepted in 20 cycles, required acceptance");
    end
  endtask

  task automatic applyStimulus(input logic [KEY_W-1:0] key, input int nbits,
                               output int firstEdge, output int firstStalls, output int lastEdge);
    int e, s;
    for (int i = 0; i < nbits; i++) begin
      sendBit(key[KEY_W-1-i], (i == 0), e, s);
      if (i == 0) begin
        firstEdge   = e;
        firstStalls = s;
      end
      lastEdge = e;
    end
  endtask

  task automatic sendFrame(input logic [KEY_W-1:0] key, output int firstEdge, output int firstStalls,
                           output int lastEdge);
    applyStimulus(key, KEY_W, firstEdge, firstStalls, lastEdge);
`ifdef DYLOCK_KEY_PARITY_EN
    begin
      int s;
      sendBit(^key, 1'b0, lastEdge, s);
    end
`endif
  endtask

  function automatic commit_t mkCommit(input logic [KEY_W-1:0] k, input int c);
    commit_t x;
    x.key = k;
    x.cyc = c;
    return x;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f, s, l, e, s2;
    rst = 1'b1; key_valid = 1'b0; key_bit = 1'b0; key_sof = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("ready_during_reset", 32'(key_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_static_key", 32'(static_key), 32'h0);
    checkOutput("reset_loaded", 32'(key_loaded), 32'd0);
    checkOutput("reset_update", 32'(key_update), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("ready_after_reset", 32'(key_ready), 32'd1);
    @(posedge clk); #1;
    monOn = 1'b1;

    // Non-sof bit in IDLE is swallowed without error or state change.
    sendBit(1'b1, 1'b0, e, s);
    @(negedge clk);
    checkOutput("idle_drop_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    sendFrame(16'hA5C3, f, s, l);
    commitQ.push_back(mkCommit(16'hA5C3, l + 1));
    idleCycles(3);
    checkOutput("first_key", 32'(static_key), 32'hA5C3);
    checkOutput("first_loaded", 32'(key_loaded), 32'd1);
    checkOutput("first_drained", 32'(commitQ.size()), 32'd0);

    // Stall mid-frame for TIMEOUT cycles: abort, key preserved.
    applyStimulus(16'h5A5A, 8, f, s, l);
    errQ.push_back(l + TIMEOUT);
    idleCycles(TIMEOUT + 3);
    checkOutput("timeout_key_kept", 32'(static_key), 32'hA5C3);
    checkOutput("timeout_idle", 32'(busy), 32'd0);
    checkOutput("timeout_drained", 32'(errQ.size()), 32'd0);

    // A gap one cycle short of TIMEOUT must not abort.
    applyStimulus(16'hC0DE, 4, f, s, l);
    idleCycles(TIMEOUT - 1);
    for (int i = 4; i < KEY_W; i++) sendBit(16'hC0DE >> (KEY_W - 1 - i), 1'b0, l, s);
`ifdef DYLOCK_KEY_PARITY_EN
    sendBit(1'b0, 1'b0, l, s);
`endif
    commitQ.push_back(mkCommit(16'hC0DE, l + 1));
    idleCycles(3);
    checkOutput("gap_key", 32'(static_key), 32'hC0DE);

    // Restart with a new sof after 5 bits.
    applyStimulus(16'hFFFF, 5, f, s, l);
    sendFrame(16'h1234, f, s, l);
    commitQ.push_back(mkCommit(16'h1234, l + 1));
    idleCycles(3);
    checkOutput("restart_key", 32'(static_key), 32'h1234);

    // Reset in the middle of a frame.
    applyStimulus(16'h0F0F, 10, f, s, l);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_ready", 32'(key_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_key", 32'(static_key), 32'h0);
    checkOutput("midreset_loaded", 32'(key_loaded), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_ready_after", 32'(key_ready), 32'd1);
    @(posedge clk); #1;
    sendFrame(16'hFFFF, f, s, l);
    commitQ.push_back(mkCommit(16'hFFFF, l + 1));
    idleCycles(3);
    checkOutput("post_reset_key", 32'(static_key), 32'hFFFF);
    checkOutput("post_reset_loaded", 32'(key_loaded), 32'd1);

`ifdef DYLOCK_KEY_PARITY_EN
    applyStimulus(16'h0001, KEY_W, f, s, l);
    sendBit(1'b0, 1'b0, l, s);
    errQ.push_back(l);
    idleCycles(3);
    checkOutput("bad_parity_key_kept", 32'(static_key), 32'hFFFF);
    applyStimulus(16'h0001, KEY_W, f, s, l);
    sendBit(1'b1, 1'b0, l, s);
    commitQ.push_back(mkCommit(16'h0001, l + 1));
    idleCycles(3);
    checkOutput("good_parity_key", 32'(static_key), 32'h0001);
`endif

    // Back-to-back frames: the next sof waits out COMMIT and lands on the first IDLE cycle.
    sendFrame(16'h3C96, f, s, l);
    commitQ.push_back(mkCommit(16'h3C96, l + 1));
    sendFrame(16'h6E21, f, s2, e);
    commitQ.push_back(mkCommit(16'h6E21, e + 1));
    checkOutput("b2b_commit_stall", 32'(s2), 32'd1);
    checkOutput("b2b_first_edge", 32'(f), 32'(l + 2));
    idleCycles(3);
    checkOutput("b2b_key", 32'(static_key), 32'h6E21);

    checkOutput("final_commit_queue", 32'(commitQ.size()), 32'd0);
    checkOutput("final_err_queue", 32'(errQ.size()), 32'd0);
    monOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
